// File: rtl/iir_run_controller_if.sv
// Bundle between iir_run_controller (slave) and the host/filter side (master).
// Signal prefixes are relative to the controller: i_ = into it, o_ = out of it.
interface iir_run_controller_if;
    logic               i_start;
    logic               i_stop;
    logic               i_cfg_req;
    logic signed [31:0] i_cfg_b1;
    logic signed [31:0] i_cfg_b2;
    logic signed [31:0] i_cfg_a2;
    logic               i_filt_valid;
    logic               i_filt_full;
    logic               o_cfg_ready;
    logic               o_cfg_ack;
    logic               o_cfg_err;
    logic               o_filt_enable;
    logic               o_filt_reset_n;
    logic signed [31:0] o_filt_b1;
    logic signed [31:0] o_filt_b2;
    logic signed [31:0] o_filt_a2;
    logic               o_out_valid;
    logic               o_done;
    logic [2:0]         o_state;

    modport slave (
        input  i_start, i_stop, i_cfg_req, i_cfg_b1, i_cfg_b2, i_cfg_a2,
               i_filt_valid, i_filt_full,
        output o_cfg_ready, o_cfg_ack, o_cfg_err, o_filt_enable, o_filt_reset_n,
               o_filt_b1, o_filt_b2, o_filt_a2, o_out_valid, o_done, o_state
    );

    modport master (
        output i_start, i_stop, i_cfg_req, i_cfg_b1, i_cfg_b2, i_cfg_a2,
               i_filt_valid, i_filt_full,
        input  o_cfg_ready, o_cfg_ack, o_cfg_err, o_filt_enable, o_filt_reset_n,
               o_filt_b1, o_filt_b2, o_filt_a2, o_out_valid, o_done, o_state
    );
endinterface

// File: rtl/iir_run_controller.sv
// Sequences enable, active-low reset and coefficients of the single-pole IIR stage.
// Optional build macro COEF_CHECK_EN: reject unstable or all-zero coefficient sets.
//
// state  | meaning
// IDLE   | filter disabled and held in reset, waiting for start/cfg_req
// LOAD   | new coefficients driven with filter disabled, LOAD_CYCLES long
// FLUSH  | filter reset asserted for FLUSH_CYCLES to clear its state
// SETTLE | filter running, first SETTLE_SAMPLES valid beats discarded
// RUN    | filter running, valid forwarded downstream
// FULL   | filter FIFO full, filter paused but holding its data
module iir_run_controller #(
    parameter int unsigned        LOAD_CYCLES    = 4,
    parameter int unsigned        FLUSH_CYCLES   = 2,
    parameter int unsigned        SETTLE_SAMPLES = 2048,
    parameter logic signed [31:0] B1_DEFAULT     = 32'sd128,
    parameter logic signed [31:0] B2_DEFAULT     = 32'sd128,
    parameter logic signed [31:0] A2_DEFAULT     = -32'sd65279
) (
    input logic                 i_clk,
    input logic                 i_rst,
    iir_run_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FULL   = 3'd5
    } state_t;

    localparam logic [15:0] LOAD_LAST     = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] FLUSH_LAST    = 16'(FLUSH_CYCLES - 1);
    localparam logic [31:0] SETTLE_TARGET = 32'(SETTLE_SAMPLES);

    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [31:0]        r_samples;
    logic               r_restart;
    logic               r_cfg_ready;
    logic               r_cfg_ack;
    logic               r_cfg_err;
    logic               r_filt_enable;
    logic               r_filt_reset_n;
    logic signed [31:0] r_filt_b1;
    logic signed [31:0] r_filt_b2;
    logic signed [31:0] r_filt_a2;
    logic               r_out_valid;
    logic               r_done;

    state_t      w_state_next;
    logic [15:0] w_cnt_next;
    logic [31:0] w_samples_next;
    logic [31:0] w_samples_inc;
    logic        w_restart_next;
    logic        w_coef_load;
    logic        w_cfg_err_next;
    logic        w_ack_on_abort;
    logic        w_cfg_accept;
    logic        w_coef_ok;

`ifdef COEF_CHECK_EN
    assign w_coef_ok = !(($signed(bus.i_cfg_a2) >= 32'sd65536) ||
                         ($signed(bus.i_cfg_a2) <= -32'sd65536) ||
                         ((bus.i_cfg_b1 == 32'sd0) && (bus.i_cfg_b2 == 32'sd0)));
`else
    assign w_coef_ok = 1'b1;
`endif

    assign w_cfg_accept  = r_cfg_ready && bus.i_cfg_req && !bus.i_stop;
    assign w_samples_inc = (r_samples == '1) ? r_samples : r_samples + 32'd1;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_samples_next = r_samples;
        w_restart_next = r_restart;
        w_coef_load    = 1'b0;
        w_cfg_err_next = 1'b0;
        w_ack_on_abort = 1'b0;
        if (bus.i_stop) begin
            w_state_next   = S_IDLE;
            // an aborted load still owes the requester its ack; if the last
            // LOAD cycle is current the ack is already on the wire
            w_ack_on_abort = (r_state == S_LOAD) && (r_cnt != 16'd0);
        end else if (w_cfg_accept && w_coef_ok) begin
            w_state_next   = S_LOAD;
            w_cnt_next     = LOAD_LAST;
            w_restart_next = (r_state == S_RUN);
            w_coef_load    = 1'b1;
        end else if (w_cfg_accept) begin
            w_cfg_err_next = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_FULL: begin
                    if (bus.i_start) begin
                        w_state_next   = S_FLUSH;
                        w_cnt_next     = FLUSH_LAST;
                        w_samples_next = 32'd0;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == 16'd0) begin
                        if (r_restart) begin
                            w_state_next   = S_FLUSH;
                            w_cnt_next     = FLUSH_LAST;
                            w_samples_next = 32'd0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt - 16'd1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 16'd0) w_state_next = S_SETTLE;
                    else                w_cnt_next   = r_cnt - 16'd1;
                end
                S_SETTLE: begin
                    if (SETTLE_TARGET == 32'd0) begin
                        w_state_next = S_RUN;
                    end else if (bus.i_filt_valid) begin
                        w_samples_next = w_samples_inc;
                        if (w_samples_inc >= SETTLE_TARGET) w_state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.i_filt_full) w_state_next = S_FULL;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 16'd0;
            r_samples      <= 32'd0;
            r_restart      <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_cfg_ack      <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_filt_enable  <= 1'b0;
            r_filt_reset_n <= 1'b0;
            r_filt_b1      <= B1_DEFAULT;
            r_filt_b2      <= B2_DEFAULT;
            r_filt_a2      <= A2_DEFAULT;
            r_out_valid    <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_samples      <= w_samples_next;
            r_restart      <= w_restart_next;
            r_cfg_ready    <= (w_state_next == S_IDLE) || (w_state_next == S_RUN) ||
                              (w_state_next == S_FULL);
            r_cfg_ack      <= ((w_state_next == S_LOAD) && (w_cnt_next == 16'd0)) ||
                              w_ack_on_abort;
            r_cfg_err      <= w_cfg_err_next;
            r_filt_enable  <= (w_state_next == S_SETTLE) || (w_state_next == S_RUN);
            r_filt_reset_n <= (w_state_next == S_SETTLE) || (w_state_next == S_RUN) ||
                              (w_state_next == S_FULL);
            r_out_valid    <= (r_state == S_RUN) && (w_state_next == S_RUN) &&
                              bus.i_filt_valid;
            r_done         <= (w_state_next == S_FULL);
            if (w_coef_load) begin
                r_filt_b1 <= bus.i_cfg_b1;
                r_filt_b2 <= bus.i_cfg_b2;
                r_filt_a2 <= bus.i_cfg_a2;
            end
        end
    end

    assign bus.o_state        = r_state;
    assign bus.o_cfg_ready    = r_cfg_ready;
    assign bus.o_cfg_ack      = r_cfg_ack;
    assign bus.o_cfg_err      = r_cfg_err;
    assign bus.o_filt_enable  = r_filt_enable;
    assign bus.o_filt_reset_n = r_filt_reset_n;
    assign bus.o_filt_b1      = r_filt_b1;
    assign bus.o_filt_b2      = r_filt_b2;
    assign bus.o_filt_a2      = r_filt_a2;
    assign bus.o_out_valid    = r_out_valid;
    assign bus.o_done         = r_done;

endmodule
